// File: rtl/pkt_fetch_pkg.sv
// Shared types and helpers for the packet fetch stage: FSM state encoding,
// word geometry and the length-to-words / trailing-empty conversions.
package pkt_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        READ   = 3'd2,
        WAIT_D = 3'd3,
        SEND   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // Low address bits that must be cleared to get a word-aligned address.
    localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

    // Number of 32-bit words needed to carry len bytes (32-bit arithmetic).
    function automatic logic [31:0] len_to_words(input logic [31:0] len);
        return (len + 32'd3) >> 2;
    endfunction

    // Unused bytes in the final word: (4 - len[1:0]) mod 4.
    function automatic logic [1:0] len_to_empty(input logic [31:0] len);
        logic [2:0] diff;
        diff = 3'd4 - {1'b0, len[1:0]};
        return diff[1:0];
    endfunction

endpackage

// File: rtl/pkt_fetch.sv
// Packet fetch stage: pops word addresses from a show-ahead FIFO, reads each
// word over an Avalon-MM master (one read outstanding) and streams the packet
// out on Avalon-ST with SOP/EOP/empty. One packet in flight at a time.
//
// Handshakes: a stream beat transfers on a cycle where st_valid and st_ready
// are both high at the rising clk edge; st_valid never drops and st_data never
// changes until that happens. An Avalon read is accepted on a cycle where
// avm_read=1 and avm_waitrequest=0; address and read stay fixed until then.
module pkt_fetch
    import pkt_fetch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int MAX_LEN = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       pkt_len,
    input  logic [ADDR_W-1:0] fifo_q,
    input  logic              fifo_empty,
    output logic              fifo_rdreq,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [31:0]       st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop,
    output logic [1:0]        st_empty,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [31:0]       words_left_q, words_left_d;
    logic              first_q, first_d;
    logic [1:0]        empty_last_q, empty_last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              zero_done_q, zero_done_d;
    logic              err_q, err_d;
    logic              last_word;

    assign last_word = (words_left_q == 32'd1);

    // State and datapath registers; synchronous active-low reset clears all.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            first_q      <= 1'b0;
            empty_last_q <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            zero_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            first_q      <= first_d;
            empty_last_q <= empty_last_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            zero_done_q  <= zero_done_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic and register updates for the fetch sequence.
    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        first_d      = first_q;
        empty_last_d = empty_last_q;
        addr_d       = addr_q;
        data_d       = data_q;
        zero_done_d  = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (pkt_len == 32'd0) begin
                        // Empty packet: nothing to fetch, just acknowledge.
                        zero_done_d = 1'b1;
                    end else if (pkt_len > 32'(MAX_LEN)) begin
                        err_d = 1'b1;
                    end else begin
                        words_left_d = len_to_words(pkt_len);
                        empty_last_d = len_to_empty(pkt_len);
                        first_d      = 1'b1;
                        state_d      = POP;
                    end
                end
            end
            POP: begin
                if (!fifo_empty) begin
                    addr_d  = {fifo_q[ADDR_W-1:2], fifo_q[1:0] & ~ADDR_ALIGN_MASK};
                    state_d = READ;
                end
            end
            READ: begin
                if (!avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        // Zero-latency slave returns data in the accept cycle.
                        data_d  = avm_readdata;
                        state_d = SEND;
                    end else begin
                        state_d = WAIT_D;
                    end
                end
            end
            WAIT_D: begin
                if (avm_readdatavalid) begin
                    data_d  = avm_readdata;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (st_ready) begin
                    first_d      = 1'b0;
                    words_left_d = words_left_q - 32'd1;
                    state_d      = last_word ? DONE : POP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        fifo_rdreq  = (state_q == POP) && !fifo_empty;
        avm_read    = (state_q == READ);
        avm_address = addr_q;
        st_valid    = (state_q == SEND);
        st_data     = data_q;
        st_sop      = (state_q == SEND) && first_q;
        st_eop      = (state_q == SEND) && last_word;
        st_empty    = ((state_q == SEND) && last_word) ? empty_last_q : 2'b00;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE) || zero_done_q;
        err         = err_q;
    end

endmodule

// File: tb/tb_pkt_fetch.sv
// Bench for pkt_fetch: FIFO and Avalon-MM slave models, a stream sink with
// programmable back-pressure, and a scoreboard of expected stream beats.
module tb_pkt_fetch;

  localparam int ADDR_W  = 32;
  localparam int MAX_LEN = 2048;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pkt_len = '0;
  logic [31:0] fifo_q = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rdreq;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready = 1'b1;
  logic        st_sop;
  logic        st_eop;
  logic [1:0]  st_empty;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  pkt_fetch #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .pkt_len           (pkt_len),
    .fifo_q            (fifo_q),
    .fifo_empty        (fifo_empty),
    .fifo_rdreq        (fifo_rdreq),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .st_data           (st_data),
    .st_valid          (st_valid),
    .st_ready          (st_ready),
    .st_sop            (st_sop),
    .st_eop            (st_eop),
    .st_empty          (st_empty),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  // ---------------- scoreboard state ----------------
  logic [35:0] exp_q[$];          // {sop, eop, empty[1:0], data}
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [95:0] outs();
    return {fifo_rdreq, avm_read, avm_address, st_data, st_valid, st_sop,
            st_eop, st_empty, busy, done, err};
  endfunction

  // ---------------- environment models ----------------
  logic [31:0] fifo_mem[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] acc_addr_q[$];
  int  stall_rd_n = 0;
  int  stall_st_n = 0;
  int  rd_wait_cnt = 0;
  int  st_wait_cnt = 0;
  bit  slave_auto = 1'b1;
  logic        man_dv = 1'b0;
  logic [31:0] man_data = '0;
  int  pop_cnt = 0;
  int  acc_cnt = 0;
  int  cyc = 0;

  // Sample DUT requests at the edge, then update FIFO/slave/sink just after.
  always @(posedge clk) begin
    logic pop_s, acc_s, rd_stall_s, st_stall_s, beat_s;
    logic [31:0] a_s;
    pop_s      = fifo_rdreq;
    acc_s      = avm_read && !avm_waitrequest;
    rd_stall_s = avm_read && avm_waitrequest;
    st_stall_s = st_valid && !st_ready;
    beat_s     = st_valid && st_ready;
    a_s        = avm_address;
    cyc++;
    #1;
    if (pop_s) begin
      pop_cnt++;
      if (fifo_mem.size() > 0) void'(fifo_mem.pop_front());
    end
    fifo_empty = (fifo_mem.size() == 0);
    fifo_q     = fifo_empty ? 32'h0 : fifo_mem[0];
    if (acc_s) begin
      acc_cnt++;
      acc_addr_q.push_back(a_s);
      rd_wait_cnt = 0;
    end else if (rd_stall_s) begin
      rd_wait_cnt++;
    end
    avm_waitrequest = (rd_wait_cnt < stall_rd_n);
    if (beat_s) st_wait_cnt = 0;
    else if (st_stall_s) st_wait_cnt++;
    st_ready = (st_wait_cnt >= stall_st_n);
    if (slave_auto) begin
      avm_readdatavalid = acc_s;
      avm_readdata      = acc_s ? (mem.exists(a_s) ? mem[a_s] : 32'hDEAD_BEEF) : 32'h0;
    end else begin
      avm_readdatavalid = man_dv;
      avm_readdata      = man_data;
    end
  end

  // ---------------- monitor ----------------
  int beat_cnt = 0;
  int stall_rd_seen = 0;
  int stall_st_seen = 0;
  int eop_cyc = -10;
  logic prev_rd_stall = 1'b0;
  logic prev_st_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (prev_rd_stall) check("rd_hold", {avm_read, avm_address}, {1'b1, prev_addr});
    if (prev_st_stall) check("st_hold", {st_valid, st_data}, {1'b1, prev_data});
    prev_rd_stall = avm_read && avm_waitrequest;
    prev_addr     = avm_address;
    if (avm_read && avm_waitrequest) stall_rd_seen++;
    prev_st_stall = st_valid && !st_ready;
    prev_data     = st_data;
    if (st_valid && !st_ready) stall_st_seen++;
    if (st_valid && st_ready) begin
      beat_cnt++;
      if (st_eop) eop_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %0h expected none", {st_sop, st_eop, st_empty, st_data});
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        check("beat", {st_sop, st_eop, st_empty, st_data}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  int start_cyc = 0;

  task automatic do_start(input logic [31:0] len);
    @(negedge clk);
    start   = 1'b1;
    pkt_len = len;
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!done && i < 300) begin
      @(negedge clk);
      i++;
    end
    check(name, done, 1);
    check("done_after_eop", cyc - eop_cyc, 1);
  endtask

  // ---------------- stimulus ----------------
  int p0, b0, a0, r0, s0, t0;
  bit ok;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    reset = 1'b1;

    // Two words, aligned, immediate slave and sink.
    fifo_mem.push_back(32'h1000);
    fifo_mem.push_back(32'h1004);
    mem[32'h1000] = 32'h0000_000A;
    mem[32'h1004] = 32'h0000_000B;
    exp_q.push_back({1'b1, 1'b0, 2'd0, 32'h0000_000A});
    exp_q.push_back({1'b0, 1'b1, 2'd0, 32'h0000_000B});
    p0 = pop_cnt; b0 = beat_cnt;
    do_start(32'd8);
    wait_done("t1_done");
    check("t1_latency", cyc - start_cyc, 8);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_pops", pop_cnt - p0, 2);
    check("t1_beats", beat_cnt - b0, 2);

    // Unaligned FIFO address, 5-byte packet -> empty=3 on EOP.
    fifo_mem.push_back(32'h2003);
    fifo_mem.push_back(32'h2004);
    mem[32'h2000] = 32'h1122_3344;
    mem[32'h2004] = 32'h5566_7788;
    exp_q.push_back({1'b1, 1'b0, 2'd0, 32'h1122_3344});
    exp_q.push_back({1'b0, 1'b1, 2'd3, 32'h5566_7788});
    a0 = acc_addr_q.size();
    do_start(32'd5);
    wait_done("t2_done");
    check("t2_addr0", acc_addr_q[a0], 32'h2000);
    check("t2_addr1", acc_addr_q[a0+1], 32'h2004);

    // Slave stalls 3 cycles, sink stalls 4 cycles.
    stall_rd_n = 3;
    stall_st_n = 4;
    fifo_mem.push_back(32'h3000);
    mem[32'h3000] = 32'h00C0_FFEE;
    exp_q.push_back({1'b1, 1'b1, 2'd0, 32'h00C0_FFEE});
    p0 = pop_cnt; b0 = beat_cnt; r0 = stall_rd_seen; s0 = stall_st_seen;
    do_start(32'd4);
    wait_done("t3_done");
    check("t3_rd_stalls", stall_rd_seen - r0, 3);
    check("t3_st_stalls", stall_st_seen - s0, 4);
    check("t3_pops", pop_cnt - p0, 1);
    check("t3_beats", beat_cnt - b0, 1);
    stall_rd_n = 0;
    stall_st_n = 0;
    repeat (2) @(negedge clk);

    // Zero length and oversize length.
    p0 = pop_cnt; b0 = beat_cnt;
    do_start(32'd0);
    check("t4_zero_done", {busy, done, err}, 3'b010);
    @(negedge clk);
    check("t4_zero_done_pulse", {busy, done}, 2'b00);
    do_start(32'(MAX_LEN + 1));
    check("t4_err", {busy, done, err}, 3'b001);
    @(negedge clk);
    check("t4_err_pulse", {busy, err}, 2'b00);
    repeat (2) @(negedge clk);
    check("t4_pops", pop_cnt - p0, 0);
    check("t4_beats", beat_cnt - b0, 0);

    // FIFO empty for 10 cycles; a start while busy must be ignored.
    t0 = acc_cnt;
    do_start(32'd4);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      ok = ok && !fifo_rdreq && !avm_read && busy && !done && !err;
      @(negedge clk);
    end
    check("t5_hold_in_pop", ok, 1);
    check("t5_no_reads", acc_cnt - t0, 0);
    fifo_mem.push_back(32'h5000);
    mem[32'h5000] = 32'h5A5A_5A5A;
    exp_q.push_back({1'b1, 1'b1, 2'd0, 32'h5A5A_5A5A});
    @(posedge clk);
    #2;
    check("t5_pop_now", {fifo_empty, fifo_rdreq}, 2'b01);
    wait_done("t5_done");

    // Reset while waiting for read data; the late data must be dropped.
    fifo_mem.push_back(32'h6000);
    fifo_mem.push_back(32'h6004);
    fifo_mem.push_back(32'h6008);
    slave_auto = 1'b0;
    b0 = beat_cnt;
    do_start(32'd12);
    for (int i = 0; i < 20 && !avm_read; i++) @(negedge clk);
    check("t6_read_seen", avm_read, 1);
    @(negedge clk);
    check("t6_in_wait_d", {busy, avm_read, st_valid}, 3'b100);
    reset = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    check("t6_reset_outputs", outs(), 0);
    man_dv   = 1'b1;
    man_data = 32'h0000_0BAD;
    @(negedge clk);
    man_dv = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_no_beat", beat_cnt - b0, 0);
    check("t6_idle_outputs", outs(), 0);
    fifo_mem.delete();
    slave_auto = 1'b1;
    repeat (2) @(negedge clk);
    fifo_mem.push_back(32'h7000);
    mem[32'h7000] = 32'h0000_0077;
    exp_q.push_back({1'b1, 1'b1, 2'd0, 32'h0000_0077});
    do_start(32'd4);
    wait_done("t6_restart_done");

    repeat (3) @(negedge clk);
    check("final_exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pkt_fetch.md
Name: pkt_fetch

Overview:
Consumer stage behind the packet-address FIFO. It pops word addresses pushed by the read controller, fetches each word over an Avalon-MM read master, and emits the packet as an Avalon-ST stream with SOP, EOP and empty markers. It runs one packet at a time: start is a pulse carrying the packet length, and done pulses when the last word has been accepted downstream.

Parameters:
ADDR_W, 32, Avalon-MM address width and FIFO word width
MAX_LEN, 2048, maximum accepted packet length in bytes; larger lengths are rejected

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse that begins a packet; ignored unless IDLE
pkt_len  in  32  packet length in bytes, sampled when start is accepted
fifo_q  in  ADDR_W  show-ahead FIFO head, valid while fifo_empty=0
fifo_empty  in  1  FIFO empty flag
fifo_rdreq  out  1  pop strobe for the FIFO head
avm_address  out  ADDR_W  read address; bits[1:0] forced to 0
avm_read  out  1  read request
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data valid
st_data  out  32  stream data
st_valid  out  1  stream valid
st_ready  in  1  downstream ready
st_sop  out  1  first word of packet
st_eop  out  1  last word of packet
st_empty  out  2  unused bytes in the EOP word
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the EOP word is accepted
err  out  1  one-cycle pulse when a start is rejected for length

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE. All outputs 0, counters 0. This also applies mid-packet: any pending Avalon read is abandoned and its late readdatavalid is ignored, because it arrives in IDLE.
- Length rule:
  - words = (pkt_len+3)>>2, computed in 32 bits.
  - empty_last = (4 - pkt_len[1:0]) & 2'b11.
- IDLE:
  - start with pkt_len=0 -> done pulses the next cycle; no FIFO pop and no stream output; stay IDLE.
  - start with pkt_len>MAX_LEN -> err pulses the next cycle; stay IDLE.
  - Otherwise latch words_left=words and first=1, then go to POP.
- POP:
  - If fifo_empty=1, wait with no timeout.
  - Otherwise assert fifo_rdreq for exactly 1 cycle.
  - Latch fifo_q with bits[1:0] cleared into the address register, then go to READ.
- READ:
  - avm_read=1 and avm_address held stable until a cycle with avm_waitrequest=0.
  - Then deassert avm_read and go to WAIT_D.
  - If avm_readdatavalid arrives in that same accept cycle (zero-latency slave), capture the data and go directly to SEND.
- WAIT_D:
  - On avm_readdatavalid=1, capture avm_readdata into st_data and go to SEND.
  - Only one read is outstanding at any time.
- SEND:
  - st_valid=1 with st_data held stable.
  - st_sop=first.
  - st_eop=(words_left==1); st_empty=empty_last when st_eop=1, else 0.
  - On st_valid & st_ready: first<=0 and words_left<=words_left-1.
    - If that was the EOP word -> go to DONE.
    - Otherwise -> go to POP.
- DONE: done=1 for 1 cycle, then IDLE.
- Latency per word with an immediately ready slave, FIFO and sink: POP 1 + READ 1 + WAIT_D 1 + SEND 1 = 4 cycles.
- start while busy=1 is ignored with no error.
- Words are sent little-endian as read; no byte swapping.

Decomposition:
- Package pkt_fetch_pkg holds:
  - state_t enum {IDLE, POP, READ, WAIT_D, SEND, DONE}
  - BYTES_PER_WORD=4
  - ADDR_ALIGN_MASK
  - the words/empty helper function
- No sub-module is needed. The FSM, the address/data registers and the word counter live in one module.

Test Plan:
1. pkt_len=8, FIFO holds 0x1000 and 0x1004, slave returns 0xA, 0xB at 1-cycle latency, st_ready=1 -> two stream beats: 0xA with SOP, 0xB with EOP and empty=0; exactly 2 pops; done 1 cycle after the EOP beat.
2. pkt_len=5, FIFO holds 0x2003 and 0x2004 -> first avm_address is 0x2000; 2 beats; EOP beat has st_empty=3.
3. Slave holds avm_waitrequest=1 for 3 cycles, and the sink holds st_ready=0 for 4 cycles during the SEND of a pkt_len=4 packet -> avm_address, avm_read, st_data and st_valid stay stable; no extra pop; single SOP+EOP beat.
4. pkt_len=0 -> done pulses the next cycle, no pop, no stream beat. pkt_len=MAX_LEN+1 -> err pulses, busy stays 0.
5. FIFO stays empty for 10 cycles after start (pkt_len=4) -> held in POP with fifo_rdreq=0 and no Avalon activity; proceeds as soon as fifo_empty falls.
6. reset=0 asserted while in WAIT_D of a pkt_len=12 packet, with a late readdatavalid 2 cycles later -> all outputs 0 and no stream beat; a new start then completes normally.
